key_debounce: RTL and testbench

- Input-side counterpart to the board LED drivers. Takes 4 raw, bouncy, active-low push-button pins.
- Per key: synchronizes the pin, filters bounce, and produces a clean level plus single-cycle press, release and long-press events.
- Also provides a shared "any press" strobe with the encoded key index, for LED/mode controllers.

---
 rtl/key_debounce.sv | 156 +++++++++++++++
 tb/tb_key_debounce.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Four-key push-button conditioner: 2-flop synchronizer, per-key debounce FSM,
// registered press/release/long-press pulses and a shared any-press strobe with key index.
module key_debounce #(
    parameter logic [23:0] DEBOUNCE_TICS = 24'd10,
    parameter logic [23:0] LONG_TICS     = 24'd40
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [3:0] key_n,
    output logic [3:0] key_state,
    output logic [3:0] key_press,
    output logic [3:0] key_release,
    output logic [3:0] key_long,
    output logic       press_any,
    output logic [1:0] key_code
);

    typedef enum logic [1:0] {UP, DOWN_FILT, DOWN, UP_FILT} state_t;

    state_t      state_q [4];
    state_t      state_d [4];
    logic [23:0] dcnt_q  [4];
    logic [23:0] dcnt_d  [4];
    logic [23:0] lcnt_q  [4];
    logic [23:0] lcnt_d  [4];

    logic [3:0] s1_q, s2_q, k;
    logic [3:0] level_d, press_d, release_d, long_d;
    logic [3:0] level_q, press_q, release_q, long_q;
    logic       any_d, any_q;
    logic [1:0] code_d, code_q;
    logic       found;

    assign k = ~s2_q;

    // Synchronizer resets to released (pins idle high)
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1_q <= '1;
            s2_q <= '1;
        end else begin
            s1_q <= key_n;
            s2_q <= s1_q;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int unsigned i = 0; i < 4; i++) begin
                state_q[i] <= UP;
                dcnt_q[i]  <= '0;
                lcnt_q[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                dcnt_q[i]  <= dcnt_d[i];
                lcnt_q[i]  <= lcnt_d[i];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            dcnt_d[i]  = dcnt_q[i];
            lcnt_d[i]  = lcnt_q[i];
            case (state_q[i])
                UP: begin
                    if (k[i]) begin
                        state_d[i] = DOWN_FILT;
                        dcnt_d[i]  = '0;
                    end
                end
                DOWN_FILT: begin
                    if (!k[i]) begin
                        state_d[i] = UP;
                    end else if (dcnt_q[i] == DEBOUNCE_TICS - 24'd1) begin
                        state_d[i] = DOWN;
                        lcnt_d[i]  = '0;
                    end else begin
                        dcnt_d[i] = dcnt_q[i] + 24'd1;
                    end
                end
                DOWN: begin
                    if (!k[i]) begin
                        state_d[i] = UP_FILT;
                        dcnt_d[i]  = '0;
                    end else if (lcnt_q[i] == LONG_TICS - 24'd1) begin
                        lcnt_d[i] = LONG_TICS;  // saturate: one long event per press
                    end else if (lcnt_q[i] < LONG_TICS - 24'd1) begin
                        lcnt_d[i] = lcnt_q[i] + 24'd1;
                    end
                end
                UP_FILT: begin
                    if (k[i]) begin
                        state_d[i] = DOWN;
                    end else if (dcnt_q[i] == DEBOUNCE_TICS - 24'd1) begin
                        state_d[i] = UP;
                    end else begin
                        dcnt_d[i] = dcnt_q[i] + 24'd1;
                    end
                end
                default: state_d[i] = UP;
            endcase
        end
    end

    always_comb begin
        level_d   = '0;
        press_d   = '0;
        release_d = '0;
        long_d    = '0;
        code_d    = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            level_d[i]   = (state_d[i] == DOWN) || (state_d[i] == UP_FILT);
            press_d[i]   = (state_q[i] == DOWN_FILT) && k[i] && (dcnt_q[i] == DEBOUNCE_TICS - 24'd1);
            release_d[i] = (state_q[i] == UP_FILT) && !k[i] && (dcnt_q[i] == DEBOUNCE_TICS - 24'd1);
            long_d[i]    = (state_q[i] == DOWN) && k[i] && (lcnt_q[i] == LONG_TICS - 24'd1);
        end
        for (int unsigned i = 0; i < 4; i++) begin
            if (press_d[i] && !found) begin
                code_d = i[1:0];
                found  = 1'b1;
            end
        end
        any_d = |press_d;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            any_q     <= 1'b0;
            code_q    <= '0;
        end else begin
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            any_q     <= any_d;
            code_q    <= code_d;
        end
    end

    assign key_state   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;
    assign press_any   = any_q;
    assign key_code    = code_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce: a per-cycle monitor tallies pulses and their cycle
// numbers, and each step compares those tallies against hand-computed edge numbers.
module tb_key_debounce;

    logic       sys_clk;
    logic       sys_rst_n;
    logic [3:0] key_n;
    logic [3:0] key_state, key_press, key_release, key_long;
    logic       press_any;
    logic [1:0] key_code;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pc [4], pt [4], rc [4], rt [4], lc [4], lt [4], sc [4];
    int anyc, coinc, badany, badcode, nzrst, base;
    logic [3:0] pvec;
    logic [1:0] pcode;

    key_debounce #(.DEBOUNCE_TICS(24'd10), .LONG_TICS(24'd40)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .key_n      (key_n),
        .key_state  (key_state),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long),
        .press_any  (press_any),
        .key_code   (key_code)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear();
        for (int i = 0; i < 4; i++) begin
            pc[i] = 0; pt[i] = -1; rc[i] = 0; rt[i] = -1;
            lc[i] = 0; lt[i] = -1; sc[i] = 0;
        end
        anyc = 0; pvec = '0; pcode = '0;
    endtask

    // Advance one clock edge and sample outputs 1 ns later.
    task automatic tick();
        @(posedge sys_clk);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (key_press[i])   begin pc[i]++; pt[i] = cyc; end
            if (key_release[i]) begin rc[i]++; rt[i] = cyc; end
            if (key_long[i])    begin lc[i]++; lt[i] = cyc; end
            if (key_state[i])   sc[i]++;
            if ((int'(key_press[i]) + int'(key_release[i]) + int'(key_long[i])) > 1) coinc++;
        end
        if (press_any) begin anyc++; pvec = key_press; pcode = key_code; end
        if (!press_any && key_code != 2'd0) badcode++;
        if (press_any !== (|key_press)) badany++;
        if (!sys_rst_n && ({key_state, key_press, key_release, key_long, press_any, key_code} != '0)) nzrst++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        coinc = 0; badany = 0; badcode = 0; nzrst = 0;
        clear();
        sys_rst_n = 1'b0;
        key_n     = '1;
        repeat (3) @(posedge sys_clk);
        #1;
        check("reset_outputs", 32'({key_state, key_press, key_release, key_long, press_any, key_code}), 32'd0);
        sys_rst_n = 1'b1;
        ticks(5);

        // Clean press on key 0: low for 30 sampled edges
        clear();
        key_n[0] = 1'b0;
        base = cyc + 1;
        ticks(30);
        key_n[0] = 1'b1;
        ticks(20);
        check("clean_press_time", pt[0], base + 12);
        check("clean_press_count", pc[0], 1);
        check("clean_state_cycles", sc[0], 30);
        check("clean_release_time", rt[0], base + 42);
        check("clean_release_count", rc[0], 1);
        check("clean_any_count", anyc, 1);
        check("clean_code", pcode, 0);
        check("clean_no_long", lc[0], 0);

        // Press bounce on key 1
        clear();
        for (int r = 0; r < 5; r++) begin
            key_n[1] = 1'b0; ticks(4);
            key_n[1] = 1'b1; ticks(3);
        end
        check("bounce_no_early_press", pc[1], 0);
        check("bounce_no_early_state", sc[1], 0);
        key_n[1] = 1'b0;
        base = cyc + 1;
        ticks(20);
        check("bounce_press_time", pt[1], base + 12);
        check("bounce_press_count", pc[1], 1);
        key_n[1] = 1'b1;
        ticks(20);
        check("bounce_release_count", rc[1], 1);

        // Release bounce on key 2
        key_n[2] = 1'b0;
        ticks(20);
        clear();
        for (int r = 0; r < 3; r++) begin
            key_n[2] = 1'b1; ticks(5);
            key_n[2] = 1'b0; ticks(5);
        end
        key_n[2] = 1'b1;
        base = cyc + 1;
        ticks(20);
        check("rbounce_release_time", rt[2], base + 12);
        check("rbounce_release_count", rc[2], 1);
        check("rbounce_no_press", pc[2], 0);
        check("rbounce_state_cycles", sc[2], 42);

        // Long press on key 3: low for 100 sampled edges
        clear();
        key_n[3] = 1'b0;
        base = cyc + 1;
        ticks(100);
        key_n[3] = 1'b1;
        ticks(20);
        check("long_press_time", pt[3], base + 12);
        check("long_time", lt[3], base + 52);
        check("long_count", lc[3], 1);
        check("long_release_time", rt[3], base + 112);

        // Simultaneous keys 1 and 3
        clear();
        key_n[1] = 1'b0;
        key_n[3] = 1'b0;
        base = cyc + 1;
        ticks(20);
        check("simul_any_count", anyc, 1);
        check("simul_vector", pvec, 4'b1010);
        check("simul_code", pcode, 1);
        check("simul_time", pt[1], base + 12);
        key_n = '1;
        ticks(20);

        // Reset mid-filter: key 2 accepted-down, key 0 in DOWN_FILT with dcnt=5
        key_n[2] = 1'b0;
        ticks(20);
        clear();
        key_n[0] = 1'b0;
        ticks(8);
        check("prereset_state", key_state, 4'b0100);
        sys_rst_n = 1'b0;
        #1;
        check("async_reset_state", key_state, 4'b0000);
        ticks(3);
        check("reset_hold_outputs", nzrst, 0);
        clear();
        sys_rst_n = 1'b1;
        base = cyc + 1;
        ticks(20);
        check("postreset_press0_time", pt[0], base + 12);
        check("postreset_press0_count", pc[0], 1);
        check("postreset_press2_time", pt[2], base + 12);
        check("postreset_code", pcode, 0);
        key_n = '1;
        ticks(20);

        check("no_coincident_pulses", coinc, 0);
        check("press_any_matches_or", badany, 0);
        check("code_zero_when_idle", badcode, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
